// File: rtl/lock_sequencer.sv
// lock_sequencer: sequencing controller for a 4-button combination lock.
// Compares 4-symbol key entries against a programmable code, counts
// consecutive failures, enforces lockout, auto-relocks after an open window,
// and drives the unlock status plus a 7-segment status glyph.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   key_a..key_d one-cycle key pulses (A=0, B=1, C=2, D=3)
//   prog         request code programming (honoured only while open)
//   unlocked     high while OPEN
//   locked_out   high while LOCKOUT
//   fail_cnt     consecutive failed entries
//   O            active-low segments {a,b,c,d,e,f,g}
module lock_sequencer #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned ENTRY_TIMEOUT  = 2000,
  parameter logic [7:0]  DEFAULT_CODE   = 8'b00_01_10_11
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             key_a,
  input  logic                             key_b,
  input  logic                             key_c,
  input  logic                             key_d,
  input  logic                             prog,
  output logic                             unlocked,
  output logic                             locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
  output logic [6:0]                       O
);

  localparam int unsigned FW    = $clog2(MAX_FAILS + 1);
  localparam int unsigned T_AB  = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int unsigned T_MAX = (T_AB > ENTRY_TIMEOUT) ? T_AB : ENTRY_TIMEOUT;
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  // Timers run from N-1 down to 0 so a state lasts exactly N cycles.
  localparam logic [CW-1:0] LD_TIMEOUT = CW'(ENTRY_TIMEOUT - 1);
  localparam logic [CW-1:0] LD_UNLOCK  = CW'(UNLOCK_CYCLES - 1);
  localparam logic [CW-1:0] LD_LOCKOUT = CW'(LOCKOUT_CYCLES - 1);

  localparam logic [6:0] GLYPH_U = 7'b1000001;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_P = 7'b0011000;
  localparam logic [6:0] GLYPH_L = 7'b1110001;

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_OPEN, S_PROG, S_LOCKOUT
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic            r_mismatch, w_mismatch_nxt;
  logic [7:0]      r_code, w_code_nxt;
  logic [7:0]      r_shadow, w_shadow_nxt;
  logic [FW-1:0]   r_fail_cnt, w_fail_cnt_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  logic [3:0]      w_keys;
  logic            w_any;
  logic            w_valid;
  logic [1:0]      w_sym;
  logic [1:0]      w_code_sym;
  logic            w_sym_bad;
  logic            w_expired;
  logic [FW-1:0]   w_fail_inc;
  logic [7:0]      w_shadow_wr;

  assign w_keys    = {key_d, key_c, key_b, key_a};
  assign w_any     = |w_keys;
  assign w_valid   = $onehot(w_keys);
  assign w_expired = (r_cnt == '0);
  // An invalid multi-key event always counts as a wrong symbol.
  assign w_sym_bad = ~w_valid | (w_sym != w_code_sym);
  // Saturating increment so the counter never wraps.
  assign w_fail_inc = (r_fail_cnt == FW'(MAX_FAILS)) ? r_fail_cnt : r_fail_cnt + FW'(1);

  // Key encode and symbol selection at the current position.
  always_comb begin
    w_sym       = 2'd0;
    w_code_sym  = r_code[7:6];
    w_shadow_wr = r_shadow;
    case (w_keys)
      4'b0010: w_sym = 2'd1;
      4'b0100: w_sym = 2'd2;
      4'b1000: w_sym = 2'd3;
      default: w_sym = 2'd0;
    endcase
    case (r_idx)
      2'd0: begin w_code_sym = r_code[7:6]; w_shadow_wr[7:6] = w_sym; end
      2'd1: begin w_code_sym = r_code[5:4]; w_shadow_wr[5:4] = w_sym; end
      2'd2: begin w_code_sym = r_code[3:2]; w_shadow_wr[3:2] = w_sym; end
      default: begin w_code_sym = r_code[1:0]; w_shadow_wr[1:0] = w_sym; end
    endcase
  end

  // State and datapath register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_mismatch <= 1'b0;
      r_code     <= DEFAULT_CODE;
      r_shadow   <= DEFAULT_CODE;
      r_fail_cnt <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_code     <= w_code_nxt;
      r_shadow   <= w_shadow_nxt;
      r_fail_cnt <= w_fail_cnt_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Next-state logic; timer expiry takes priority over a same-cycle key.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_mismatch_nxt = r_mismatch;
    w_code_nxt     = r_code;
    w_shadow_nxt   = r_shadow;
    w_fail_cnt_nxt = r_fail_cnt;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt    = S_ENTRY;
          w_idx_nxt      = 2'd1;
          w_mismatch_nxt = w_sym_bad;
          w_cnt_nxt      = LD_TIMEOUT;
        end
      end
      S_ENTRY: begin
        if (w_expired) begin
          w_state_nxt    = S_IDLE;
          w_idx_nxt      = 2'd0;
          w_mismatch_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (w_any) begin
            w_cnt_nxt = LD_TIMEOUT;
            if (r_idx == 2'd3) begin
              w_idx_nxt      = 2'd0;
              w_mismatch_nxt = 1'b0;
              if (!(r_mismatch | w_sym_bad)) begin
                w_state_nxt    = S_OPEN;
                w_fail_cnt_nxt = '0;
                w_cnt_nxt      = LD_UNLOCK;
              end else begin
                w_fail_cnt_nxt = w_fail_inc;
                if (w_fail_inc == FW'(MAX_FAILS)) begin
                  w_state_nxt = S_LOCKOUT;
                  w_cnt_nxt   = LD_LOCKOUT;
                end else begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
                end
              end
            end else begin
              w_idx_nxt      = r_idx + 2'd1;
              w_mismatch_nxt = r_mismatch | w_sym_bad;
            end
          end
        end
      end
      S_OPEN: begin
        if (prog) begin
          w_state_nxt = S_PROG;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = LD_TIMEOUT;
        end else if (w_expired) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_PROG: begin
        if (w_expired) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 2'd0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (w_valid) begin
            w_cnt_nxt    = LD_TIMEOUT;
            w_shadow_nxt = w_shadow_wr;
            if (r_idx == 2'd3) begin
              // Commit the full shadow, including the symbol arriving now.
              w_code_nxt  = w_shadow_wr;
              w_state_nxt = S_IDLE;
              w_idx_nxt   = 2'd0;
              w_cnt_nxt   = '0;
            end else begin
              w_idx_nxt = r_idx + 2'd1;
            end
          end
        end
      end
      S_LOCKOUT: begin
        if (w_expired) begin
          w_state_nxt    = S_IDLE;
          w_fail_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Status outputs decoded directly from the state register.
  assign unlocked   = (r_state == S_OPEN);
  assign locked_out = (r_state == S_LOCKOUT);
  assign fail_cnt   = r_fail_cnt;

  always_comb begin
    O = GLYPH_L;
    case (r_state)
      S_OPEN:    O = GLYPH_U;
      S_LOCKOUT: O = GLYPH_E;
      S_PROG:    O = GLYPH_P;
      default:   O = GLYPH_L;
    endcase
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Testbench for lock_sequencer: stimulus tasks push cycle-stamped expected
// outputs into a scoreboard; a negedge monitor pops and compares them.
module tb_lock_sequencer;

  localparam logic [3:0] KA = 4'b0001;
  localparam logic [3:0] KB = 4'b0010;
  localparam logic [3:0] KC = 4'b0100;
  localparam logic [3:0] KD = 4'b1000;

  localparam logic [6:0] GU = 7'b1000001;
  localparam logic [6:0] GE = 7'b0110000;
  localparam logic [6:0] GP = 7'b0011000;
  localparam logic [6:0] GL = 7'b1110001;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_a, key_b, key_c, key_d, prog;
  logic       unlocked, locked_out;
  logic [1:0] fail_cnt;
  logic [6:0] O;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [10:0] exp;
  } exp_t;

  exp_t sb_q[$];

  lock_sequencer #(
    .MAX_FAILS(3),
    .LOCKOUT_CYCLES(20),
    .UNLOCK_CYCLES(10),
    .ENTRY_TIMEOUT(15),
    .DEFAULT_CODE(8'b00_01_10_11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_a(key_a),
    .key_b(key_b),
    .key_c(key_c),
    .key_d(key_d),
    .prog(prog),
    .unlocked(unlocked),
    .locked_out(locked_out),
    .fail_cnt(fail_cnt),
    .O(O)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [10:0] exp_word(input logic u, input logic lo,
                                           input logic [1:0] fc, input logic [6:0] o);
    return {u, lo, fc, o};
  endfunction

  task automatic expect_at(input int c, input string tag, input logic [10:0] e);
    exp_t x;
    x.cyc = c;
    x.tag = tag;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  // Compare every expectation due in the current cycle, away from the edge.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        check_eq(sb_q[i].tag, 32'({unlocked, locked_out, fail_cnt, O}), 32'(sb_q[i].exp));
        sb_q.delete(i);
      end
    end
  end

  task automatic set_keys(input logic [3:0] k);
    {key_d, key_c, key_b, key_a} = k;
  endtask

  // One-cycle key pulse after gap idle cycles; c is the first cycle that
  // shows the effect of the sampling edge.
  task automatic pulse(input logic [3:0] k, input int gap, output int c);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    set_keys(k);
    @(posedge clk); #1;
    set_keys(4'b0000);
    c = cyc;
  endtask

  task automatic enter4(input logic [15:0] seq, input int gap, input logic [10:0] mid,
                        input string tag, output int c);
    for (int i = 0; i < 4; i++) begin
      pulse(seq[15-4*i -: 4], gap, c);
      if (i < 3) expect_at(c, tag, mid);
    end
  endtask

  task automatic pulse_prog(input logic [3:0] k, output int c);
    @(posedge clk); #1;
    prog = 1'b1;
    set_keys(k);
    @(posedge clk); #1;
    prog = 1'b0;
    set_keys(4'b0000);
    c = cyc;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, lc, r;
    rst = 1'b0;
    prog = 1'b0;
    set_keys(4'b0000);
    expect_at(1, "reset_hold", exp_word(0, 0, 2'd0, GL));
    expect_at(2, "reset_hold2", exp_word(0, 0, 2'd0, GL));
    wait_cyc(3);
    rst = 1'b1;

    // 1: default code opens for exactly 10 cycles
    enter4({KA, KB, KC, KD}, 2, exp_word(0, 0, 2'd0, GL), "s1_mid", c);
    expect_at(c,      "s1_open",      exp_word(1, 0, 2'd0, GU));
    expect_at(c + 9,  "s1_open_last", exp_word(1, 0, 2'd0, GU));
    expect_at(c + 10, "s1_relock",    exp_word(0, 0, 2'd0, GL));
    wait_cyc(12);

    // 2: three failures -> lockout of 20 cycles, keys ignored
    enter4({KA, KB, KD, KD}, 1, exp_word(0, 0, 2'd0, GL), "s2_mid1", c);
    expect_at(c, "s2_fail1", exp_word(0, 0, 2'd1, GL));
    enter4({KA, KB, KD, KD}, 1, exp_word(0, 0, 2'd1, GL), "s2_mid2", c);
    expect_at(c, "s2_fail2", exp_word(0, 0, 2'd2, GL));
    enter4({KA, KB, KD, KD}, 1, exp_word(0, 0, 2'd2, GL), "s2_mid3", c);
    lc = c;
    expect_at(lc,      "s2_lock",       exp_word(0, 1, 2'd3, GE));
    expect_at(lc + 19, "s2_lock_last",  exp_word(0, 1, 2'd3, GE));
    expect_at(lc + 20, "s2_lock_end",   exp_word(0, 0, 2'd0, GL));
    enter4({KA, KB, KC, KD}, 0, exp_word(0, 1, 2'd3, GE), "s2_lock_mid", c2);
    expect_at(c2, "s2_ignored", exp_word(0, 1, 2'd3, GE));
    wait_cyc(lc + 22 - cyc);
    enter4({KA, KB, KC, KD}, 1, exp_word(0, 0, 2'd0, GL), "s2_after_mid", c);
    expect_at(c, "s2_after_open", exp_word(1, 0, 2'd0, GU));
    wait_cyc(12);

    // 3: timeout; a key in the expiring cycle is dropped
    pulse(KA, 1, c);
    pulse(KB, 1, c);
    expect_at(c, "s3_mid", exp_word(0, 0, 2'd0, GL));
    repeat (13) @(posedge clk);
    pulse(KC, 0, c2);
    expect_at(c2, "s3_timeout", exp_word(0, 0, 2'd0, GL));
    enter4({KA, KB, KC, KD}, 1, exp_word(0, 0, 2'd0, GL), "s3_mid2", c);
    expect_at(c, "s3_open", exp_word(1, 0, 2'd0, GU));
    wait_cyc(12);

    // 4: program D,C,B,A (prog beats a same-cycle key)
    enter4({KA, KB, KC, KD}, 1, exp_word(0, 0, 2'd0, GL), "s4_mid", c);
    expect_at(c, "s4_open", exp_word(1, 0, 2'd0, GU));
    wait_cyc(1);
    pulse_prog(KA, c);
    expect_at(c, "s4_prog", exp_word(0, 0, 2'd0, GP));
    enter4({KD, KC, KB, KA}, 1, exp_word(0, 0, 2'd0, GP), "s4_prog_mid", c);
    expect_at(c, "s4_relock", exp_word(0, 0, 2'd0, GL));
    enter4({KA, KB, KC, KD}, 1, exp_word(0, 0, 2'd0, GL), "s4_old_mid", c);
    expect_at(c, "s4_old_fails", exp_word(0, 0, 2'd1, GL));
    enter4({KD, KC, KB, KA}, 1, exp_word(0, 0, 2'd1, GL), "s4_new_mid", c);
    expect_at(c, "s4_new_opens", exp_word(1, 0, 2'd0, GU));
    wait_cyc(12);

    // 5: {a,b} together in the A position of code D,C,B,A is a wrong symbol
    enter4({KD, KC, KB, KA | KB}, 1, exp_word(0, 0, 2'd0, GL), "s5_mid", c);
    expect_at(c, "s5_invalid_fail", exp_word(0, 0, 2'd1, GL));
    wait_cyc(2);

    // 6: program C,C,C,C, then reset mid-entry restores the default code
    enter4({KD, KC, KB, KA}, 1, exp_word(0, 0, 2'd1, GL), "s6_mid", c);
    expect_at(c, "s6_open", exp_word(1, 0, 2'd0, GU));
    pulse_prog(4'b0000, c);
    expect_at(c, "s6_prog", exp_word(0, 0, 2'd0, GP));
    enter4({KC, KC, KC, KC}, 1, exp_word(0, 0, 2'd0, GP), "s6_prog_mid", c);
    expect_at(c, "s6_relock", exp_word(0, 0, 2'd0, GL));
    enter4({KA, KB, KC, KD}, 1, exp_word(0, 0, 2'd0, GL), "s6_dflt_mid", c);
    expect_at(c, "s6_dflt_fails", exp_word(0, 0, 2'd1, GL));
    pulse(KC, 1, c);
    pulse(KC, 1, c);
    wait_cyc(1);
    rst = 1'b0;
    r = cyc;
    expect_at(r,     "s6_rst_async", exp_word(0, 0, 2'd0, GL));
    expect_at(r + 1, "s6_rst_hold",  exp_word(0, 0, 2'd0, GL));
    wait_cyc(2);
    rst = 1'b1;
    enter4({KA, KB, KC, KD}, 1, exp_word(0, 0, 2'd0, GL), "s6_post_mid", c);
    expect_at(c, "s6_post_open", exp_word(1, 0, 2'd0, GU));
    wait_cyc(12);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Clocked sequencing controller for the 4-button combination lock. It consumes single-cycle key pulses (A–D, already debounced and edge-detected upstream) and compares each 4-symbol entry against a programmable stored code. It counts failed attempts, enforces a lockout after repeated failures, holds the lock open for a fixed time and then relocks. It drives the unlock status and the 7-segment status glyph for the lock top level.

## Interface
- `MAX_FAILS`, default 3: consecutive failed entries that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, default 1000: clock cycles spent in LOCKOUT.
- `UNLOCK_CYCLES`, default 500: clock cycles spent in OPEN before auto-relock.
- `ENTRY_TIMEOUT`, default 2000: idle cycles allowed between keys in ENTRY/PROG.
- `DEFAULT_CODE`, default 8'b00_01_10_11: reset code. Symbol 0 is in [7:6]. Encoding: A=0, B=1, C=2, D=3.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `key_a`, `key_b`, `key_c`, `key_d`  in  1 each  one-cycle key pulses, synchronous to `clk`.
- `prog`  in  1  request code programming; sampled only in OPEN.
- `unlocked`  out  1  high exactly while the state is OPEN.
- `locked_out`  out  1  high exactly while the state is LOCKOUT.
- `fail_cnt`  out  $clog2(MAX_FAILS+1)  current count of consecutive failures.
- `O`  out  7  active-low segments {a,b,c,d,e,f,g}.

## Operation
- Key event: exactly one of `key_a..key_d` is high in a cycle.
  - Two or more high in the same cycle is an invalid event. In ENTRY or IDLE it counts as a wrong symbol. In PROG it is ignored.
- States: IDLE, ENTRY, OPEN, PROG, LOCKOUT.
- IDLE:
  - A key event sets idx=1 and mismatch=(sym≠code[0]), then goes to ENTRY.
- ENTRY:
  - Each key event advances idx and ORs its mismatch into the flag. Nothing is revealed before the 4th symbol.
  - On the 4th event, evaluate the entry:
    - Match: go to OPEN and clear `fail_cnt`.
    - Mismatch: `fail_cnt`+1. Go to LOCKOUT if the new value equals MAX_FAILS, otherwise go to IDLE.
  - If ENTRY_TIMEOUT cycles pass with no key event, go to IDLE. This does not count as a failure and leaves `fail_cnt` unchanged.
- OPEN:
  - Keys are ignored.
  - `prog`=1 goes to PROG with idx=0. If `prog` and a key arrive in the same cycle, `prog` wins and the key is dropped.
  - Otherwise go to IDLE after UNLOCK_CYCLES cycles.
- PROG:
  - Each valid key event is written into a shadow register at position idx.
  - After the 4th symbol, the shadow register is copied into `code` in the same edge and the state goes to IDLE (relocked).
  - On timeout, go to IDLE with `code` unchanged.
- LOCKOUT:
  - All keys and `prog` are ignored.
  - After LOCKOUT_CYCLES cycles, go to IDLE and clear `fail_cnt`.
- `O` glyphs:
  - OPEN: "U" = 7'b1000001
  - LOCKOUT: "E" = 7'b0110000
  - PROG: "P" = 7'b0011000
  - all other states: "L" = 7'b1110001
- One shared down-counter serves the timeout, unlock and lockout timers. It is reloaded on every state entry and on every key event in ENTRY/PROG.

## Timing
- Reset (`rst`=0, any time, including mid-entry or mid-PROG):
  - state=IDLE, idx=0, mismatch=0, `code`=DEFAULT_CODE, `fail_cnt`=0, counter=0.
  - `unlocked`=0, `locked_out`=0, `O`=7'b1110001.
  - A programmed code is not retained across reset.
- Outputs are decoded combinationally from the state register, with no added latency.
- The 4th key pulse at edge n puts the state in OPEN from cycle n+1, so `unlocked`=1 in cycle n+1.
- OPEN lasts exactly UNLOCK_CYCLES cycles. LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- Timeout fires on the ENTRY_TIMEOUT-th consecutive cycle with no key event.
- A key event in the same cycle that a timer expires is dropped; the state transition wins.
- `fail_cnt` saturates at MAX_FAILS and never wraps.

## Test plan
Parameters for all scenarios: MAX_FAILS=3, LOCKOUT_CYCLES=20, UNLOCK_CYCLES=10, ENTRY_TIMEOUT=15.
1. Reset, then pulse A,B,C,D 3 cycles apart → `unlocked`=1 the cycle after D, `O`=1000001 for exactly 10 cycles, then `O`=1110001.
2. Three entries of A,B,D,D → `fail_cnt` goes 1,2,3 → `locked_out`=1 and `O`=0110000 for 20 cycles. A,B,C,D entered during lockout is ignored. Afterwards `fail_cnt`=0 and the correct code opens the lock.
3. A,B, then 15 idle cycles → state IDLE, `fail_cnt`=0. Then A,B,C,D → opens.
4. Open, assert `prog`, enter D,C,B,A → `O`=0011000 during entry, IDLE after. A,B,C,D now fails. D,C,B,A opens.
5. Entry with {key_a,key_b} pulsed together as one symbol plus three correct keys → fail counted, `fail_cnt`=1.
6. Program a new code, then pulse `rst` low mid-entry → all outputs at reset values, and DEFAULT_CODE A,B,C,D opens again.
